// File: rtl/sc_decoder.sv
// Stochastic-computing decoder: counts the ones in a window of 2^LOG2_WORDS
// 32-bit bitstream words and strobes the total out once per completed window.
module sc_decoder #(
  parameter int LOG2_WORDS = 1,
  parameter int CW         = LOG2_WORDS + 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_in,
  input  logic [31:0]   seq_in,
  input  logic          flush,
  output logic [CW-1:0] cnt_out,
  output logic          valid_out,
  output logic          busy
);

  // A zero-width word counter is illegal, so keep at least one bit; with
  // LOG2_WORDS=0 the last index is 0 and every word completes a window.
  localparam int            WW        = (LOG2_WORDS > 0) ? LOG2_WORDS : 1;
  localparam logic [WW-1:0] WCNT_LAST = WW'((1 << LOG2_WORDS) - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    pc_r_q, pc_r_d;
  logic          pc_v_q, pc_v_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [5:0]    popcount;
  logic [CW-1:0] sum;

  // Stage 1: popcount of the incoming word.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
    popcount = '0;
    for (int i = 0; i < 32; i++) begin
      popcount = popcount + 6'(seq_in[i]);
    end
    pc_v_d = en_in && !flush;
    pc_r_d = pc_v_d ? popcount : pc_r_q;
  end

  // Stage 2: window FSM and accumulator; flush beats a completing window.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    sum     = acc_q + CW'(pc_r_q);
    if (flush) begin
      state_d = IDLE;
      wcnt_d  = '0;
      acc_d   = '0;
    end else if (pc_v_q) begin
      if (wcnt_q == WCNT_LAST) begin
        cnt_d   = sum;
        valid_d = 1'b1;
        acc_d   = '0;
        wcnt_d  = '0;
        state_d = IDLE;
      end else begin
        acc_d   = sum;
        wcnt_d  = wcnt_q + WW'(1);
        state_d = ACC;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      pc_r_q  <= '0;
      pc_v_q  <= 1'b0;
      wcnt_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_r_q  <= pc_r_d;
      pc_v_q  <= pc_v_d;
      wcnt_q  <= wcnt_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign cnt_out   = cnt_q;
  assign valid_out = valid_q;
  assign busy      = (state_q == ACC) || pc_v_q;

endmodule

// File: tb/tb_sc_decoder.sv
// Directed bench for sc_decoder at LOG2_WORDS=1 (two-word windows).
module tb_sc_decoder;

  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_in = 1'b0;
  logic [31:0]   seq_in = '0;
  logic          flush = 1'b0;
  logic [CW-1:0] cnt_out;
  logic          valid_out;
  logic          busy;

  int checks = 0;
  int errors = 0;

  sc_decoder #(.LOG2_WORDS(1), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_in     (en_in),
    .seq_in    (seq_in),
    .flush     (flush),
    .cnt_out   (cnt_out),
    .valid_out (valid_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drive on the falling edge, then look at outputs just after the rising edge.
  task automatic step(input logic e, input logic [31:0] d, input logic f, input logic r);
    @(negedge clk);
    en_in  = e;
    seq_in = d;
    flush  = f;
    rst    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic v, input int c, input logic b);
    check({tag, ".valid"}, 32'(valid_out), 32'(v));
    check({tag, ".cnt"},   32'(cnt_out),   32'(c));
    check({tag, ".busy"},  32'(busy),      32'(b));
  endtask

  initial begin
    // Reset
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    outs("reset", 1'b0, 0, 1'b0);

    // Two all-ones words -> 64, pulse two edges after the first word
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    outs("ones.w1", 1'b0, 0, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    outs("ones.w2", 1'b0, 0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    outs("ones.done", 1'b1, 64, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    outs("ones.hold", 1'b0, 64, 1'b0);

    // 16 + 8 = 24
    step(1'b1, 32'h0000_FFFF, 1'b0, 1'b0);
    step(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    outs("mix.done", 1'b1, 24, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    outs("mix.after", 1'b0, 24, 1'b0);

    // Gap of three idle cycles between the two words: 4 + 4 = 8
    step(1'b1, 32'h0000_000F, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0);
      outs($sformatf("gap.idle%0d", i), 1'b0, 24, 1'b1);
    end
    step(1'b1, 32'h0000_00F0, 1'b0, 1'b0);
    outs("gap.w2", 1'b0, 24, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    outs("gap.done", 1'b1, 8, 1'b0);

    // Four back-to-back all-ones words: pulses two cycles apart
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    outs("b2b.e1", 1'b0, 8, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    outs("b2b.e2", 1'b0, 8, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    outs("b2b.e3", 1'b1, 64, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    outs("b2b.e4", 1'b0, 64, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    outs("b2b.e5", 1'b1, 64, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    outs("b2b.e6", 1'b0, 64, 1'b0);

    // Flush discards a partial window; the next two words give 2
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    outs("flush.edge", 1'b0, 64, 1'b0);
    step(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    outs("flush.w2", 1'b0, 64, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    outs("flush.done", 1'b1, 2, 1'b0);

    // Flush coinciding with window completion wins; word presented with flush is dropped
    step(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    step(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    outs("flwin.edge", 1'b0, 2, 1'b0);
    step(1'b1, 32'h0000_0003, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    outs("flwin.done", 1'b1, 3, 1'b0);

    // Reset mid-window overrides en_in, then a fresh window of zeros
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    outs("rst.partial", 1'b0, 3, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    outs("rst.during", 1'b0, 0, 1'b0);
    step(1'b1, 32'h0, 1'b0, 1'b0);
    outs("rst.w1", 1'b0, 0, 1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b0);
    outs("rst.w2", 1'b0, 0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    outs("rst.done", 1'b1, 0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    outs("rst.after", 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
